// File: rtl/wb_retire_q.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_q
// Purpose  : Writeback/retire stage. A single stage register S captures the
//            MEM2 result through a valid/ready handshake and drives the
//            register-file write/forward bus. Retired entries move from S
//            into a DEPTH-entry trace FIFO drained by a back-pressurable
//            commit-trace consumer. A 64-bit retired-instruction counter is
//            kept alongside.
// Ports    : clk, rst_n (async, active low), flush
//            in_valid/in_ready/in_bus   - MEM2 input handshake
//            fwd_we/fwd_waddr/fwd_wdata - RF write / ID forward bus from S
//            trace_*                    - FIFO head, valid/ready handshake
//            instret                    - retired-instruction count
//            q_count                    - FIFO occupancy
// Options  : WB_X0_SQUASH_EN - when defined, entries targeting x0 have
//            rf_we and rf_wdata forced to 0 at capture into S.
// Revision : 1.0 - initial release
// ============================================================================
module wb_retire_q #(
  parameter  int XLEN  = 64,
  parameter  int DEPTH = 4,
  localparam int IN_WD = 2*XLEN + 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WD-1:0]         in_bus,
  output logic                     fwd_we,
  output logic [4:0]               fwd_waddr,
  output logic [XLEN-1:0]          fwd_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [XLEN-1:0]          trace_pc,
  output logic [31:0]              trace_inst,
  output logic [7:0]               trace_we,
  output logic [4:0]               trace_wnum,
  output logic [XLEN-1:0]          trace_wdata,
  output logic [63:0]              instret,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  // --------------------------------------------------------------------------
  // Input unpack and capture conditioning
  // --------------------------------------------------------------------------
  entry_t in_entry;
  entry_t cap_entry;

  assign in_entry = entry_t'(in_bus);

  always_comb begin
    cap_entry = in_entry;
`ifdef WB_X0_SQUASH_EN
    // x0 writes become architectural no-ops before they reach the RF or trace.
    if (in_entry.waddr == 5'd0) begin
      cap_entry.we    = 1'b0;
      cap_entry.wdata = '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          s_valid_q, s_valid_d;
  entry_t        s_q, s_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   instret_q, instret_d;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic full, empty, pop, retire, push, accept;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = !empty && trace_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take S.
  assign retire = s_valid_q && (!full || pop);
  // Flush kills S before it can commit: no push, no count.
  assign push   = retire && !flush;
  assign in_ready = !s_valid_q || retire;
  assign accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s_valid_d = s_valid_q;
    s_d       = s_q;
    if (flush) begin
      s_valid_d = 1'b0;
      s_d       = '0;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_d       = cap_entry;
    end else if (retire) begin
      // Fields are left in place; fwd_we is qualified by s_valid.
      s_valid_d = 1'b0;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    instret_d = instret_q;

    if (push) begin
      mem_d[wr_ptr_q] = s_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      instret_d       = instret_q + 64'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_q       <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      instret_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s_valid_q <= s_valid_d;
      s_q       <= s_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      instret_q <= instret_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign fwd_we      = s_valid_q && s_q.we;
  assign fwd_waddr   = s_q.waddr;
  assign fwd_wdata   = s_q.wdata;

  assign trace_valid = !empty;
  assign trace_pc    = head.pc;
  assign trace_inst  = head.inst;
  assign trace_we    = {8{head.we}};
  assign trace_wnum  = head.waddr;
  assign trace_wdata = head.wdata;

  assign instret     = instret_q;
  assign q_count     = count_q;

endmodule
`default_nettype wire

// File: doc/wb_retire_q.md
Name: wb_retire_q

Overview:
- Parametrised writeback/retire stage that replaces the single-register writeback stage.
- Takes the MEM2 result through a valid/ready handshake and holds it in one stage register, S. S drives the register-file write/forward bus.
- Retired instructions move from S into a DEPTH-entry trace FIFO, drained by a back-pressurable debug/commit-trace consumer.
- Also maintains a 64-bit retired-instruction counter.

Parameters:
- XLEN, 64, data/PC width (32 or 64).
- DEPTH, 4, trace FIFO entries; power of two, >=2.
- IN_WD, 2*XLEN+38, input bus width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the entry in S.
- in_valid  in  1  MEM2 bus valid.
- in_ready  out  1  stage accepts in_bus this cycle.
- in_bus  in  IN_WD  {rf_we, rf_waddr[4:0], rf_wdata[XLEN], pc[XLEN], inst[31:0]}, MSB first.
- fwd_we  out  1  RF write enable / ID forward enable.
- fwd_waddr  out  5  RF write address.
- fwd_wdata  out  XLEN  RF write data.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts head.
- trace_pc  out  XLEN  head pc.
- trace_inst  out  32  head instruction.
- trace_we  out  8  {8{head rf_we}}.
- trace_wnum  out  5  head rf_waddr.
- trace_wdata  out  XLEN  head rf_wdata.
- instret  out  64  retired-instruction count.
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by system): s_valid=0, S fields=0, FIFO pointers/count=0, instret=0. All outputs 0 except in_ready=1.
- S retire condition: retire = s_valid && (!full || (trace_valid && trace_ready)). A pop frees space in the same cycle, so push-when-full-with-pop is legal.
- in_ready = !s_valid || retire (combinational; no dependency on in_valid).
- Accept = in_valid && in_ready. On the edge, S loads in_bus and s_valid=1. If retire occurs without accept, s_valid=0.
- Flush: highest priority. s_valid=0 and S fields cleared on the edge, even if accept or retire occurs that cycle.
  - A flushed S entry is not pushed, not counted, and not traced.
  - FIFO contents are committed history and are never flushed.
- fwd_we = s_valid && S.rf_we; fwd_waddr and fwd_wdata come from S.
  - Forward holds every cycle S is stalled. Repeated RF writes of identical data are intended and harmless.
- Latency: accepted at edge N -> fwd visible in cycle N..N+1 -> pushed at edge N+1 if space -> trace_valid in cycle N+1 after that edge. Minimum two edges from input to trace head.
- FIFO:
  - wr/rd pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count range 0..DEPTH; full = (count==DEPTH), empty = (count==0).
  - Simultaneous push/pop: count unchanged, both pointers advance.
  - Pop when empty is impossible, since trace_valid=0.
- Trace outputs show the FIFO head and stay stable while trace_valid && !trace_ready.
- instret: +1 on each retire; wraps 2^64-1 -> 0.
- Throughput is one instruction per cycle while trace_ready=1.
- Reset mid-operation discards S and the FIFO immediately and asynchronously.

Optional Feature:
- Macro WB_X0_SQUASH_EN.
- Defined: an entry with rf_waddr==0 has rf_we forced to 0 at capture into S. fwd_we and trace_we stay 0 for x0 writes, and fwd_wdata/trace_wdata for that entry are 0.
- Undefined: rf_we/rf_wdata pass unmodified; the consumer and the RF ignore x0.
- No other behaviour changes in either case.

Test Plan:
- Reset with in_valid=1 -> in_ready=1, fwd_we=0, trace_valid=0, instret=0, q_count=0.
- Stream 8 back-to-back entries (pc=0x1000+4i, rf_we=1, waddr=i+1, wdata=i) with trace_ready=1 -> one trace per cycle in order, first trace_valid 2 edges after first accept, instret=8.
- trace_ready=0, push 6 entries (DEPTH=4) -> q_count=4, S held with fwd_we=1 for entry 5, in_ready=0. Raise trace_ready -> pops and pushes in the same cycle, all 6 delivered in order, no loss or duplication.
- flush asserted in the same cycle as accept of pc=0x2000 while S holds pc=0x1FFC -> neither is traced, instret unchanged, q_count unchanged, FIFO entries preserved.
- Pointer wrap: 3*DEPTH+1 entries with trace_ready toggling every cycle -> order preserved, q_count never exceeds 4.
- Entry waddr=0, rf_we=1, wdata=0xDEAD -> with WB_X0_SQUASH_EN: fwd_we=0, trace_we=0x00, trace_wdata=0. Without it: fwd_we=1, trace_we=0xFF, trace_wdata=0xDEAD.
